// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

  localparam int DM_LANES  = 4;
  localparam int DM_WORD_W = 32;
  localparam int DM_CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } dm_state_e;

endpackage : dm_pkg

// File: rtl/dm_byte_ram.sv
// Byte-lane organised word storage: one 8-bit array per lane, synchronous
// per-lane write, asynchronous read of the addressed word. Not reset.
module dm_byte_ram
  import dm_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                 i_clk,
  input  logic [DM_LANES-1:0]  i_we,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DM_WORD_W-1:0] i_wdata,
  output logic [DM_WORD_W-1:0] o_rdata
);

  // Index only with the bits the array needs; callers gate out-of-range
  // addresses before they reach the write enables or the read result.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDX_W-1:0] w_idx;

  assign w_idx = i_addr[IDX_W-1:0];

  for (genvar g = 0; g < DM_LANES; g++) begin : g_lane
    logic [7:0] r_mem [DEPTH];

    // Lane write: only this lane's enable and data byte
    always_ff @(posedge i_clk) begin
      if (i_we[g]) r_mem[w_idx] <= i_wdata[8*g +: 8];
    end

    assign o_rdata[8*g +: 8] = r_mem[w_idx];
  end

endmodule : dm_byte_ram

// File: rtl/dm_mem_responder.sv
// Memory-side responder: accepts a word request, waits WAIT_CYCLES,
// performs a byte-lane write or a word read, returns the word with a
// one-cycle ready pulse. No lane shifting or extension happens here.
module dm_mem_responder
  import dm_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req,
  input  logic [DM_LANES-1:0]  wea,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DM_WORD_W-1:0] wdata,
  output logic [DM_WORD_W-1:0] rdata,
  output logic                 ready,
  output logic                 err
);

  localparam logic [DM_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? DM_CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  dm_state_e             r_state;
  dm_state_e             w_state_nxt;
  logic [DM_CNT_W-1:0]   r_cnt;
  logic [DM_CNT_W-1:0]   w_cnt_nxt;
  logic                  w_capture;
  logic                  w_access;

  logic [ADDR_W-1:0]     r_addr;
  logic [DM_LANES-1:0]   r_wea;
  logic [DM_WORD_W-1:0]  r_wdata;

  logic [ADDR_W-1:0]     w_acc_addr;
  logic [DM_LANES-1:0]   w_acc_wea;
  logic [DM_WORD_W-1:0]  w_acc_wdata;
  logic                  w_in_range;
  logic [DM_WORD_W-1:0]  w_ram_rdata;
  logic [DM_WORD_W-1:0]  w_merged;
  logic [DM_LANES-1:0]   w_ram_we;

  logic [DM_WORD_W-1:0]  r_rdata;
  logic                  r_ready;
  logic                  r_err;

  // State and wait counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and access-edge decode
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_RESP;
            w_access    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture on accept; held through WAIT so later input changes are ignored
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_wea   <= '0;
      r_wdata <= '0;
    end else if (w_capture) begin
      r_addr  <= addr;
      r_wea   <= wea;
      r_wdata <= wdata;
    end
  end

  // With zero wait states the access edge is the accept edge, so the access
  // must use the live inputs; otherwise it uses the captured request.
  assign w_acc_addr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_acc_wea   = (r_state == S_IDLE) ? wea   : r_wea;
  assign w_acc_wdata = (r_state == S_IDLE) ? wdata : r_wdata;

  assign w_in_range = ({1'b0, w_acc_addr} < DEPTH_X);

  // Write enables reach storage only on an in-range access edge outside reset
  assign w_ram_we = (w_access && w_in_range && rstn) ? w_acc_wea : '0;

  dm_byte_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_acc_addr),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Post-write word: enabled lanes from the request, others from storage
  always_comb begin
    w_merged = '0;
    for (int unsigned i = 0; i < DM_LANES; i++) begin
      w_merged[8*i +: 8] = w_acc_wea[i] ? w_acc_wdata[8*i +: 8]
                                        : w_ram_rdata[8*i +: 8];
    end
  end

  // Response registers: load on the access edge, pulse clears leaving RESP
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_access) begin
      r_ready <= 1'b1;
      r_err   <= ~w_in_range;
      r_rdata <= w_in_range ? w_merged : '0;
    end else if (r_state == S_RESP) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end
  end

  assign rdata = r_rdata;
  assign ready = r_ready;
  assign err   = r_err;

endmodule : dm_mem_responder
